// File: rtl/gpio_avalon_arb_if.sv
// rtl/gpio_avalon_arb_if.sv - Avalon-MM master/slave signal bundle shared by arbiter ports
interface gpio_avalon_arb_if #(
    parameter int addr_w = 3,
    parameter int data_w = 32
);
    logic [addr_w-1:0] address;
    logic [data_w-1:0] writedata;
    logic              write;
    logic              read;
    logic              chipselect;
    logic              waitrequest;
    logic [data_w-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, writedata, write, read, chipselect,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, writedata, write, read, chipselect,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/gpio_avalon_arb.sv
// rtl/gpio_avalon_arb.sv - two-master round-robin Avalon-MM arbiter for one GPIO slave
// Optional read-timeout abort with sticky timeout_err when ARB_TIMEOUT_EN is defined.
module gpio_avalon_arb #(
    parameter int addr_w = 3,
    parameter int data_w = 32
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int rd_timeout = 15
`endif
) (
    input  logic                clk,
    input  logic                rstn,
    gpio_avalon_arb_if.slave    m0,
    gpio_avalon_arb_if.slave    m1,
    gpio_avalon_arb_if.master   s,
    output logic                timeout_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

    state_t state_q, state_d;
    logic   owner_q, owner_d;
    logic   last_q, last_d;
    logic   is_rd_q, is_rd_d;

    logic              req0, req1, own_req, own_wr, own_rd;
    logic [addr_w-1:0] own_addr, s_addr;
    logic [data_w-1:0] own_wdata, s_wdata, rd_data, rdd0, rdd1;
    logic              s_wr, s_rd, s_cs, rd_valid;
    logic              wait0, wait1, rdv0, rdv1;

`ifdef ARB_TIMEOUT_EN
    localparam logic [4:0] rd_limit = 5'(rd_timeout);
    logic [4:0] cnt_q, cnt_d;
    logic       terr_q, terr_d;
`endif

    assign req0      = m0.chipselect & (m0.read | m0.write);
    assign req1      = m1.chipselect & (m1.read | m1.write);
    assign own_req   = owner_q ? req1         : req0;
    assign own_wr    = owner_q ? m1.write     : m0.write;
    assign own_rd    = owner_q ? m1.read      : m0.read;
    assign own_addr  = owner_q ? m1.address   : m0.address;
    assign own_wdata = owner_q ? m1.writedata : m0.writedata;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        is_rd_d  = is_rd_q;
        s_addr   = '0;
        s_wdata  = '0;
        s_wr     = 1'b0;
        s_rd     = 1'b0;
        s_cs     = 1'b0;
        wait0    = 1'b1;
        wait1    = 1'b1;
        rd_valid = 1'b0;
        rd_data  = '0;
`ifdef ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        terr_d   = terr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    // A tie goes to whichever master did not win last time.
                    owner_d = (req0 & req1) ? ~last_q : req1;
                    last_d  = owner_d;
                    is_rd_d = owner_d ? (m1.read & ~m1.write) : (m0.read & ~m0.write);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (owner_q) wait1 = 1'b0;
                else         wait0 = 1'b0;
                s_addr  = own_addr;
                s_wdata = own_wdata;
                if (own_req) begin
                    s_cs    = 1'b1;
                    s_wr    = own_wr;
                    s_rd    = own_rd & ~own_wr;
                    state_d = is_rd_q ? WAIT_RD : IDLE;
                end else begin
                    state_d = IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                cnt_d = '0;
`endif
            end
            WAIT_RD: begin
                rd_valid = s.readdatavalid;
                rd_data  = s.readdata;
                if (s.readdatavalid) begin
                    state_d = IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == rd_limit) begin
                    rd_valid = 1'b1;
                    rd_data  = '0;
                    terr_d   = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Read data is steered to the owner only; the other master sees zeros.
    assign rdv0 = rd_valid & ~owner_q;
    assign rdv1 = rd_valid &  owner_q;
    assign rdd0 = owner_q ? '0 : rd_data;
    assign rdd1 = owner_q ? rd_data : '0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            is_rd_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= '0;
            terr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            is_rd_q <= is_rd_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
`endif
        end
    end

`ifdef ARB_TIMEOUT_EN
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign s.address          = s_addr;
    assign s.writedata        = s_wdata;
    assign s.write            = s_wr;
    assign s.read             = s_rd;
    assign s.chipselect       = s_cs;
    assign m0.waitrequest     = wait0;
    assign m1.waitrequest     = wait1;
    assign m0.readdatavalid   = rdv0;
    assign m1.readdatavalid   = rdv1;
    assign m0.readdata        = rdd0;
    assign m1.readdata        = rdd1;
endmodule

// File: tb/tb_gpio_avalon_arb.sv
// tb/tb_gpio_avalon_arb.sv - scoreboard bench for gpio_avalon_arb with register-file reference model
module tb_gpio_avalon_arb;
    localparam int AW = 3;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rstn;
    logic timeout_err;
    always #5 clk = ~clk;

    gpio_avalon_arb_if #(.addr_w(AW), .data_w(DW)) m0_if ();
    gpio_avalon_arb_if #(.addr_w(AW), .data_w(DW)) m1_if ();
    gpio_avalon_arb_if #(.addr_w(AW), .data_w(DW)) s_if ();

    gpio_avalon_arb #(.addr_w(AW), .data_w(DW)) dut (
        .clk(clk), .rstn(rstn), .m0(m0_if), .m1(m1_if), .s(s_if), .timeout_err(timeout_err)
    );

    logic          m_cs [2];
    logic          m_rd [2];
    logic          m_wr [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_wd [2];
    logic          m_wait [2];
    logic          m_rdv [2];
    logic [DW-1:0] m_rdd [2];

    assign m0_if.chipselect = m_cs[0];
    assign m0_if.read       = m_rd[0];
    assign m0_if.write      = m_wr[0];
    assign m0_if.address    = m_addr[0];
    assign m0_if.writedata  = m_wd[0];
    assign m1_if.chipselect = m_cs[1];
    assign m1_if.read       = m_rd[1];
    assign m1_if.write      = m_wr[1];
    assign m1_if.address    = m_addr[1];
    assign m1_if.writedata  = m_wd[1];
    assign m_wait[0] = m0_if.waitrequest;
    assign m_wait[1] = m1_if.waitrequest;
    assign m_rdv[0]  = m0_if.readdatavalid;
    assign m_rdv[1]  = m1_if.readdatavalid;
    assign m_rdd[0]  = m0_if.readdata;
    assign m_rdd[1]  = m1_if.readdata;

    logic          s_rdv;
    logic [DW-1:0] s_rdd;
    assign s_if.readdatavalid = s_rdv;
    assign s_if.readdata      = s_rdd;
    assign s_if.waitrequest   = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] slv_mem [8];
    logic [DW-1:0] ref_mem [8];
    logic [DW-1:0] exp_q0 [$];
    logic [DW-1:0] exp_q1 [$];
    int lat = 1;
    int rd_cnt = 0;
    logic [DW-1:0] rd_buf;
    bit stray_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // GPIO slave: register file, read data returned lat cycles after the read strobe.
    initial begin
        s_rdv = 1'b0;
        s_rdd = '0;
        forever begin
            @(negedge clk);
            if (s_if.chipselect && s_if.write) slv_mem[s_if.address] = s_if.writedata;
            if (s_if.chipselect && s_if.read) begin
                rd_cnt = lat;
                rd_buf = slv_mem[s_if.address];
            end
            @(posedge clk);
            #1;
            s_rdv = 1'b0;
            s_rdd = $urandom;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    s_rdv = 1'b1;
                    s_rdd = rd_buf;
                end
            end else if (stray_en && $urandom_range(0, 7) == 0) begin
                s_rdv = 1'b1;
            end
        end
    end

    // Monitor: every readdatavalid pulse must match the oldest expectation for that master.
    initial begin
        forever begin
            @(negedge clk);
            if (m_rdv[0]) begin
                if (exp_q0.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL m0_unexpected_rdv: got readdatavalid=1 data 0x%08h, required no pulse", m_rdd[0]);
                end else chk("m0_readdata", m_rdd[0], exp_q0.pop_front());
            end
            if (m_rdv[1]) begin
                if (exp_q1.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL m1_unexpected_rdv: got readdatavalid=1 data 0x%08h, required no pulse", m_rdd[1]);
                end else chk("m1_readdata", m_rdd[1], exp_q1.pop_front());
            end
        end
    end

    task automatic mst_tx(input int i, input bit is_wr, input bit both,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        int guard = 0;
        m_cs[i] = 1'b1; m_wr[i] = is_wr; m_rd[i] = !is_wr || both;
        m_addr[i] = a;  m_wd[i] = d;
        do begin
            @(negedge clk);
            guard++;
        end while (m_wait[i] && guard < 200);
        if (m_wait[i]) begin
            n_cmp++; n_err++;
            $display("FAIL m%0d_grant_timeout: waitrequest still 1 after %0d cycles, required 0", i, guard);
        end else if (is_wr) begin
            ref_mem[a] = d;
        end else if (i == 0) begin
            exp_q0.push_back(ref_mem[a]);
        end else begin
            exp_q1.push_back(ref_mem[a]);
        end
        tick();
        m_cs[i] = 1'b0; m_wr[i] = 1'b0; m_rd[i] = 1'b0;
    endtask

    task automatic rand_master(input int i, input int n);
        repeat (n) begin
            repeat ($urandom_range(0, 3)) tick();
            mst_tx(i, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                   AW'($urandom_range(0, 7)), $urandom);
        end
    endtask

    task automatic drive(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_cs[i] = 1'b1; m_wr[i] = w; m_rd[i] = !w; m_addr[i] = a; m_wd[i] = d;
    endtask

    task automatic release_m(input int i);
        m_cs[i] = 1'b0; m_wr[i] = 1'b0; m_rd[i] = 1'b0;
    endtask

    initial begin
        int c;
        for (int i = 0; i < 8; i++) begin
            slv_mem[i] = i * 32'h0101_0101;
            ref_mem[i] = i * 32'h0101_0101;
        end
        for (int i = 0; i < 2; i++) begin
            m_cs[i] = 1'b0; m_rd[i] = 1'b0; m_wr[i] = 1'b0; m_addr[i] = '0; m_wd[i] = '0;
        end
        rstn = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_m0_wait", m_wait[0], 1);
        chk("rst_m1_wait", m_wait[1], 1);
        chk("rst_m0_rdv", m_rdv[0], 0);
        chk("rst_m1_rdv", m_rdv[1], 0);
        chk("rst_s_cs", s_if.chipselect, 0);
        chk("rst_s_write", s_if.write, 0);
        chk("rst_timeout_err", timeout_err, 0);

        // Both masters write continuously: grants alternate m0, m1 every two cycles.
        tick();
        drive(0, 1'b1, 3'd3, 32'h11);
        drive(1, 1'b1, 3'd4, 32'h22);
        for (int k = 1; k <= 8; k++) begin
            tick();
            @(negedge clk);
            chk($sformatf("rr_m0_wait_k%0d", k), m_wait[0], !(k == 1 || k == 5));
            chk($sformatf("rr_m1_wait_k%0d", k), m_wait[1], !(k == 3 || k == 7));
            chk($sformatf("rr_s_write_k%0d", k), s_if.write, (k % 2) == 1);
            if (k % 2 == 1)
                chk($sformatf("rr_s_addr_k%0d", k), s_if.address, (k == 1 || k == 5) ? 3 : 4);
        end
        release_m(0);
        release_m(1);
        ref_mem[3] = 32'h11;
        ref_mem[4] = 32'h22;

        // Single m0 write.
        tick();
        drive(0, 1'b1, 3'd1, 32'h0000_00A5);
        tick();
        @(negedge clk);
        chk("w_s_write", s_if.write, 1);
        chk("w_s_read", s_if.read, 0);
        chk("w_s_addr", s_if.address, 1);
        chk("w_s_wdata", s_if.writedata, 32'h0000_00A5);
        chk("w_m0_wait", m_wait[0], 0);
        chk("w_m1_wait", m_wait[1], 1);
        tick();
        release_m(0);
        ref_mem[1] = 32'h0000_00A5;
        @(negedge clk);
        chk("w_m0_wait_after", m_wait[0], 1);
        chk("w_s_write_after", s_if.write, 0);

        // m1 read routed only to m1.
        slv_mem[2] = 32'h1234_5678;
        ref_mem[2] = 32'h1234_5678;
        tick();
        drive(1, 1'b0, 3'd2, '0);
        tick();
        exp_q1.push_back(32'h1234_5678);
        @(negedge clk);
        chk("r_s_read", s_if.read, 1);
        chk("r_s_addr", s_if.address, 2);
        chk("r_m1_wait", m_wait[1], 0);
        tick();
        release_m(1);
        @(negedge clk);
        chk("r_m1_rdv", m_rdv[1], 1);
        chk("r_m1_data", m_rdd[1], 32'h1234_5678);
        chk("r_m0_rdv", m_rdv[0], 0);

        // m1 write stalled behind an m0 read.
        tick();
        drive(0, 1'b0, 3'd5, '0);
        tick();
        exp_q0.push_back(ref_mem[5]);
        @(negedge clk);
        chk("s_m0_wait", m_wait[0], 0);
        drive(1, 1'b1, 3'd6, 32'hCAFE);
        tick();
        release_m(0);
        @(negedge clk);
        chk("s_m1_wait_n2", m_wait[1], 1);
        chk("s_m0_rdv_n2", m_rdv[0], 1);
        tick();
        @(negedge clk);
        chk("s_m1_wait_n3", m_wait[1], 1);
        chk("s_write_n3", s_if.write, 0);
        tick();
        @(negedge clk);
        chk("s_m1_wait_n4", m_wait[1], 0);
        chk("s_write_n4", s_if.write, 1);
        chk("s_addr_n4", s_if.address, 6);
        tick();
        release_m(1);
        ref_mem[6] = 32'hCAFE;

        // Reset while waiting on read data: the late response must be dropped.
        lat = 2;
        tick();
        drive(0, 1'b0, 3'd5, '0);
        tick();
        @(negedge clk);
        chk("x_m0_wait", m_wait[0], 0);
        tick();
        release_m(0);
        rstn = 1'b0;
        @(negedge clk);
        chk("x_m0_rdv_wait", m_rdv[0], 0);
        tick();
        rstn = 1'b1;
        @(negedge clk);
        chk("x_m0_rdv", m_rdv[0], 0);
        chk("x_m1_rdv", m_rdv[1], 0);
        chk("x_m0_wait_idle", m_wait[0], 1);
        chk("x_m1_wait_idle", m_wait[1], 1);
        lat = 1;
        tick();
        drive(0, 1'b1, 3'd0, 32'h77);
        drive(1, 1'b1, 3'd7, 32'h88);
        tick();
        @(negedge clk);
        chk("x_tie_m0_wait", m_wait[0], 0);
        chk("x_tie_m1_wait", m_wait[1], 1);
        tick();
        release_m(0);
        release_m(1);
        ref_mem[0] = 32'h77;

`ifdef ARB_TIMEOUT_EN
        // Silent slave: abort with zero data on the 16th WAIT_RD cycle.
        lat = 40;
        tick();
        drive(0, 1'b0, 3'd5, '0);
        tick();
        exp_q0.push_back('0);
        tick();
        release_m(0);
        c = 2;
        while (c < 40) begin
            @(negedge clk);
            if (m_rdv[0]) break;
            tick();
            c++;
        end
        chk("to_cycle", c, 17);
        chk("to_err_set", timeout_err, 1);
        repeat (45) tick();
        chk("to_err_sticky", timeout_err, 1);
        lat = 1;
`else
        c = 0;
        chk("to_err_tied", timeout_err, c);
`endif

        // Randomized traffic from both masters with stray slave readdatavalid pulses.
        stray_en = 1'b1;
        fork
            rand_master(0, 60);
            rand_master(1, 60);
        join
        stray_en = 1'b0;
        c = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && c < 20) begin
            tick();
            c++;
        end
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL drain: %0d/%0d reads outstanding, required 0/0", exp_q0.size(), exp_q1.size());
        end
        repeat (3) tick();
        for (int i = 0; i < 8; i++)
            chk($sformatf("mem_%0d", i), slv_mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/gpio_avalon_arb.md
Name: gpio_avalon_arb

Overview:
- Two-master Avalon-MM arbiter in front of one GPIO Avalon slave (register file with 3-bit address, 32-bit data, fixed 1-cycle read latency via readdatavalid).
- Lets e.g. the Nios data master and a hardware sequencer share one GPIO instance.
- Round-robin grant; one transaction outstanding at a time; per-master waitrequest back-pressure; read data routed back to its owner only.

Parameters:
- addr_w, 3, address width on all ports
- data_w, 32, data width on all ports
- rd_timeout, 15, cycles allowed in WAIT_RD before abort (used only with ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- m0_address / m1_address  in  addr_w  master address
- m0_writedata / m1_writedata  in  data_w  master write data
- m0_write / m1_write  in  1  write strobe
- m0_read / m1_read  in  1  read strobe
- m0_chipselect / m1_chipselect  in  1  master select
- m0_waitrequest / m1_waitrequest  out  1  stall; command held by master while high
- m0_readdata / m1_readdata  out  data_w  read data
- m0_readdatavalid / m1_readdatavalid  out  1  read data valid, one-cycle pulse
- s_address  out  addr_w  to slave
- s_writedata  out  data_w  to slave
- s_write / s_read / s_chipselect  out  1  to slave
- s_readdata  in  data_w  from slave
- s_readdatavalid  in  1  from slave
- timeout_err  out  1  sticky read-timeout flag (0 without macro)

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is synchronous, active-low.
- Request: reqX = mX_chipselect & (mX_read | mX_write).
- FSM states: IDLE, ISSUE, WAIT_RD. State registers: owner (1 bit), last (1 bit), is_rd (1 bit).
- Reset values: state=IDLE, last=1 (m0 wins first tie), owner=0, timeout_err=0.
- Output defaults: all s_* strobes 0; both waitrequest 1; both readdatavalid 0.
- IDLE:
  - Only one reqX: owner<=X.
  - Both req: owner<=~last.
  - Any request: last<=owner_next, is_rd<=read&~write of the winner, ->ISSUE.
- ISSUE:
  - s_* driven combinationally from owner's inputs.
  - s_write = mO_write; s_read = mO_read & ~mO_write (write wins if both set).
  - mO_waitrequest=0, other master stays 1.
  - Next state: ->WAIT_RD if is_rd, else ->IDLE.
  - If owner's reqO dropped (protocol violation): no slave strobe, ->IDLE.
- WAIT_RD:
  - mO_readdata = s_readdata.
  - mO_readdatavalid = s_readdatavalid.
  - On s_readdatavalid: ->IDLE.
  - Non-owner readdatavalid always 0; its readdata is 0.
- Latency:
  - Request seen in IDLE at cycle N; accepted (waitrequest low) at N+1.
  - Read data at N+2.
  - Throughput: write every 2 cycles, read every 3.
- Boundaries:
  - New requests during ISSUE/WAIT_RD are stalled, not lost.
  - s_readdatavalid outside WAIT_RD is ignored.
  - Reset mid-read discards the outstanding read: no readdatavalid to either master after reset.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - 5-bit counter cleared on entry to WAIT_RD, increments each WAIT_RD cycle.
  - If it reaches rd_timeout with no s_readdatavalid: pulse mO_readdatavalid with readdata=0, set timeout_err=1, ->IDLE.
  - timeout_err is cleared only by reset.
- Undefined: WAIT_RD waits indefinitely; timeout_err tied 0; no counter logic.

Test Plan:
- m0 write addr 1, data 0x0000_00A5, m1 idle -> s_write=1, s_address=1 at N+1; m0_waitrequest low only at N+1; state back to IDLE at N+2.
- m1 read addr 2, slave returns 0x1234_5678 one cycle later -> m1_readdatavalid pulse at N+2 with 0x1234_5678; m0_readdatavalid stays 0.
- m0 and m1 both request writes continuously from reset -> grants m0, m1, m0, m1 on slave cycles N+1, N+3, N+5, N+7.
- m0 read in WAIT_RD while m1 asserts write -> m1_waitrequest held 1 until m0 data returns, then m1 write issued 2 cycles later.
- rstn low in WAIT_RD, slave returns data next cycle -> no readdatavalid on either master; state IDLE; last=1.
- ARB_TIMEOUT_EN, rd_timeout=15, slave never responds -> m0_readdatavalid with 0 after 15 WAIT_RD cycles; timeout_err=1 until reset.
